// File: rtl/cpu_pkg.sv
// Shared CPU definitions: Wishbone byte-select constant, the instruction
// fetch responder state encoding and the reset fetch address.
package cpu_pkg;

   // All four byte lanes selected for a 32-bit Wishbone read
   localparam logic [3:0] SEL_ALL = 4'hF;

   // Fetch address used by the fetch stage out of reset
   localparam logic [31:0] BOOT_ADDRESS = 32'h0000_0000;

   // Instruction responder: serving hits, or refilling the line from the bus
   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } imem_state_e;

endpackage

// File: rtl/cpu_imem_line.sv
// Single instruction line: LINE_WORDS x 32-bit words, one synchronous write
// port used by the refill and one asynchronous read port used by the hit path.
module cpu_imem_line
   import cpu_pkg::*;
#(
   parameter  int LINE_WORDS = 4,
   localparam int LW_BITS    = $clog2(LINE_WORDS)
) (
   input  logic               clk_i,
   input  logic               we,
   input  logic [LW_BITS-1:0] widx,
   input  logic [31:0]        wdata,
   input  logic [LW_BITS-1:0] ridx,
   output logic [31:0]        rdata
);

   logic [31:0] words [LINE_WORDS];

   // Refill writes one word per acknowledged bus beat; contents need no reset
   // because the top keeps the line marked invalid until a full refill lands
   always_ff @(posedge clk_i) begin
      if (we) begin
         words[widx] <= wdata;
      end
   end

   assign rdata = words[ridx];

endmodule

// File: rtl/cpu_imem_responder.sv
// Instruction fetch responder: one-line instruction buffer in front of a
// read-only classic Wishbone master. Hits answer one cycle after the address;
// misses burst-refill the whole line from word 0 and then retry the compare.
module cpu_imem_responder
   import cpu_pkg::*;
#(
   parameter  int LINE_WORDS = 4,
   localparam int LW_BITS    = $clog2(LINE_WORDS)
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] imem_address_i,
   output logic [31:0] imem_data_o,
   output logic        imem_valid_o,
   output logic        imem_err_o,
   input  logic        invalidate_i,
   output logic [31:0] wb_adr_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [3:0]  wb_sel_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i
);

   localparam int TAG_W = 30 - LW_BITS;

   imem_state_e        state_q, state_d;
   logic               line_valid_q, line_valid_d;
   logic [TAG_W-1:0]   tag_q, tag_d;
   logic [LW_BITS-1:0] count_q, count_d;
   logic               inv_pend_q, inv_pend_d;
   logic [31:0]        data_q, data_d;
   logic               valid_q, valid_d;
   logic               err_q, err_d;
   logic [31:0]        adr_q, adr_d;
   logic               cyc_q, cyc_d;

   logic [TAG_W-1:0]   addr_tag;
   logic [LW_BITS-1:0] addr_idx;
   logic [LW_BITS-1:0] count_inc;
   logic [31:0]        line_rdata;
   logic               line_we;
   logic               hit;
   logic               unused_byte_bits;

   assign addr_tag         = imem_address_i[31:LW_BITS+2];
   assign addr_idx         = imem_address_i[LW_BITS+1:2];
   assign count_inc        = count_q + LW_BITS'(1);
   assign unused_byte_bits = ^imem_address_i[1:0];

   // An invalidate in the same cycle as the compare forces a miss
   assign hit = line_valid_q && (tag_q == addr_tag) && !invalidate_i;

   cpu_imem_line #(
      .LINE_WORDS(LINE_WORDS)
   ) u_line (
      .clk_i (clk_i),
      .we    (line_we),
      .widx  (count_q),
      .wdata (wb_dat_i),
      .ridx  (addr_idx),
      .rdata (line_rdata)
   );

   // Next-state and next-output logic for the hit/refill state machine
   always_comb begin
      state_d      = state_q;
      line_valid_d = line_valid_q;
      tag_d        = tag_q;
      count_d      = count_q;
      inv_pend_d   = inv_pend_q;
      data_d       = data_q;
      valid_d      = 1'b0;
      err_d        = 1'b0;
      adr_d        = adr_q;
      cyc_d        = cyc_q;
      line_we      = 1'b0;

      unique case (state_q)
         IDLE: begin
            data_d  = line_rdata;
            valid_d = hit;
            if (invalidate_i) begin
               line_valid_d = 1'b0;
            end
            if (!hit) begin
               state_d      = FILL;
               line_valid_d = 1'b0;
               tag_d        = addr_tag;
               count_d      = '0;
               inv_pend_d   = 1'b0;
               adr_d        = {addr_tag, {LW_BITS{1'b0}}, 2'b00};
               cyc_d        = 1'b1;
            end
         end
         FILL: begin
            if (invalidate_i) begin
               inv_pend_d = 1'b1;
            end
            if (wb_err_i) begin
               state_d      = IDLE;
               cyc_d        = 1'b0;
               err_d        = 1'b1;
               line_valid_d = 1'b0;
               inv_pend_d   = 1'b0;
            end else if (wb_ack_i) begin
               line_we = 1'b1;
               count_d = count_inc;
               adr_d   = {tag_q, count_inc, 2'b00};
               if (count_q == LW_BITS'(LINE_WORDS - 1)) begin
                  state_d      = IDLE;
                  cyc_d        = 1'b0;
                  line_valid_d = !(inv_pend_q || invalidate_i);
                  inv_pend_d   = 1'b0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cyc_d   = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset drops the bus cycle immediately
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         line_valid_q <= 1'b0;
         tag_q        <= '0;
         count_q      <= '0;
         inv_pend_q   <= 1'b0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         err_q        <= 1'b0;
         adr_q        <= '0;
         cyc_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         line_valid_q <= line_valid_d;
         tag_q        <= tag_d;
         count_q      <= count_d;
         inv_pend_q   <= inv_pend_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         err_q        <= err_d;
         adr_q        <= adr_d;
         cyc_q        <= cyc_d;
      end
   end

   assign imem_data_o  = data_q;
   assign imem_valid_o = valid_q;
   assign imem_err_o   = err_q;
   assign wb_adr_o     = adr_q;
   assign wb_cyc_o     = cyc_q;
   assign wb_stb_o     = cyc_q;
   assign wb_we_o      = 1'b0;
   assign wb_sel_o     = SEL_ALL;

endmodule
